// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline interlock: mult/div state encoding,
// register-zero constant, default unit latencies and the source-match helper.
package pipe_ctrl_pkg;

    localparam logic [0:0] MD_IDLE = 1'b0;
    localparam logic [0:0] MD_BUSY = 1'b1;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int DEF_MULT_CYCLES = 4;
    localparam int DEF_DIV_CYCLES  = 32;
    localparam int DEF_CNT_W       = 6;

    // $0 is hardwired, so a producer writing it can never create a dependency.
    function automatic logic reg_match(input logic [4:0] waddr,
                                       input logic [4:0] src,
                                       input logic       used);
        return used && (waddr != REG_ZERO) && (waddr == src);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Mult/div occupancy tracker: IDLE/BUSY FSM plus a down-counter that pulses
// md_done_o in the cycle HI/LO is written.
module md_busy_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic clock,
    input  logic reset_n,
    input  logic mult_start_i,
    input  logic div_start_i,
    input  logic flush_i,
    output logic md_busy_o,
    output logic md_done_o
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cntZero;

    assign cntZero = (cnt_q == '0);

    // A flush always wins; starts are only honoured from IDLE, div over mult.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else if (state_q == MD_IDLE) begin
            if (div_start_i) begin
                state_d = MD_BUSY;
                cnt_d   = DIV_LOAD;
            end else if (mult_start_i) begin
                state_d = MD_BUSY;
                cnt_d   = MULT_LOAD;
            end
        end else if (cntZero) begin
            state_d = MD_IDLE;
        end else begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign md_busy_o = (state_q == MD_BUSY);
    assign md_done_o = md_busy_o & cntZero & ~flush_i;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock: load-use, branch-on-load and HI/LO hazards drive PC/IF_ID
// enables and the ID/EX bubble. Optional STALL_PERF_EN adds a stall-cycle counter.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_use_rs,
    input  logic        ID_use_rt,
    input  logic        ID_is_branch,
    input  logic        ID_use_hilo,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_waddr,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_waddr,
    input  logic        EX_mult_start,
    input  logic        EX_div_start,
    input  logic        ex_flush,
    output logic        PC_write,
    output logic        IF_ID_write,
    output logic        ID_EX_bubble,
    output logic        md_busy,
    output logic        md_done
`ifdef STALL_PERF_EN
    ,
    output logic [31:0] stall_count
`endif
);

    logic loadUse, brLoad, hiloHaz, stall;

    md_busy_counter #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_md_busy_counter (
        .clock        (clock),
        .reset_n      (reset_n),
        .mult_start_i (EX_mult_start),
        .div_start_i  (EX_div_start),
        .flush_i      (ex_flush),
        .md_busy_o    (md_busy),
        .md_done_o    (md_done)
    );

    assign loadUse = ID_EX_MemRead &
                     (reg_match(ID_EX_waddr, ID_rs, ID_use_rs) |
                      reg_match(ID_EX_waddr, ID_rt, ID_use_rt));

    // Branches compare in ID, so a load still in MEM cannot be forwarded in time.
    assign brLoad  = ID_is_branch & EX_MEM_MemRead &
                     (reg_match(EX_MEM_waddr, ID_rs, ID_use_rs) |
                      reg_match(EX_MEM_waddr, ID_rt, ID_use_rt));

    assign hiloHaz = ID_use_hilo & (EX_mult_start | EX_div_start | (md_busy & ~md_done));

    assign stall        = (loadUse | brLoad | hiloHaz) & ~ex_flush;
    assign PC_write     = ~stall;
    assign IF_ID_write  = ~stall;
    assign ID_EX_bubble = stall | ex_flush;

`ifdef STALL_PERF_EN
    logic [31:0] stallCount_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stallCount_q <= '0;
        end else if (stall) begin
            stallCount_q <= stallCount_q + 32'd1;
        end
    end

    assign stall_count = stallCount_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: hazard vector table, multi-cycle
// corner sequences and a randomized run against a timeline model (STALL_PERF_EN aware).
module tb_hazard_stall_ctrl;

    logic        clock;
    logic        resetN;
    logic [4:0]  idRs, idRt, exWaddr, memWaddr;
    logic        useRs, useRt, isBranch, useHilo, exRead, memRead;
    logic        multStart, divStart, flush;
    logic        pcWrite, ifIdWrite, bubble, mdBusy, mdDone;
`ifdef STALL_PERF_EN
    logic [31:0] stallCount;
`endif

    int checkCount = 0;
    int errorCount = 0;

    hazard_stall_ctrl dut (
        .clock          (clock),
        .reset_n        (resetN),
        .ID_rs          (idRs),
        .ID_rt          (idRt),
        .ID_use_rs      (useRs),
        .ID_use_rt      (useRt),
        .ID_is_branch   (isBranch),
        .ID_use_hilo    (useHilo),
        .ID_EX_MemRead  (exRead),
        .ID_EX_waddr    (exWaddr),
        .EX_MEM_MemRead (memRead),
        .EX_MEM_waddr   (memWaddr),
        .EX_mult_start  (multStart),
        .EX_div_start   (divStart),
        .ex_flush       (flush),
        .PC_write       (pcWrite),
        .IF_ID_write    (ifIdWrite),
        .ID_EX_bubble   (bubble),
        .md_busy        (mdBusy),
        .md_done        (mdDone)
`ifdef STALL_PERF_EN
        ,
        .stall_count    (stallCount)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] rs, rt;
        logic       useRs, useRt, isBranch, useHilo, exRead;
        logic [4:0] exWaddr;
        logic       memRead;
        logic [4:0] memWaddr;
        logic       flush;
        logic       expPc, expIfId, expBubble;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkVec(
        input logic [4:0] rs, input logic [4:0] rt, input logic uRs, input logic uRt,
        input logic br, input logic hilo, input logic exR, input logic [4:0] exW,
        input logic memR, input logic [4:0] memW, input logic fl,
        input logic ePc, input logic eIfId, input logic eBub);
        vec_t v;
        v.rs = rs; v.rt = rt; v.useRs = uRs; v.useRt = uRt; v.isBranch = br;
        v.useHilo = hilo; v.exRead = exR; v.exWaddr = exW; v.memRead = memR;
        v.memWaddr = memW; v.flush = fl;
        v.expPc = ePc; v.expIfId = eIfId; v.expBubble = eBub;
        return v;
    endfunction

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, actual, expected);
        end
    endtask

`ifdef STALL_PERF_EN
    task automatic checkWord(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask
`endif

    task automatic checkOutput(input string tag, input logic ePc, input logic eIfId,
                               input logic eBub, input logic eBusy, input logic eDone);
        checkBit({tag, ".PC_write"},     pcWrite,   ePc);
        checkBit({tag, ".IF_ID_write"},  ifIdWrite, eIfId);
        checkBit({tag, ".ID_EX_bubble"}, bubble,    eBub);
        checkBit({tag, ".md_busy"},      mdBusy,    eBusy);
        checkBit({tag, ".md_done"},      mdDone,    eDone);
    endtask

    task automatic setIdle();
        idRs = '0; idRt = '0; exWaddr = '0; memWaddr = '0;
        useRs = 0; useRt = 0; isBranch = 0; useHilo = 0; exRead = 0; memRead = 0;
        multStart = 0; divStart = 0; flush = 0;
    endtask

    task automatic applyStimulus(input vec_t v);
        idRs = v.rs; idRt = v.rt; useRs = v.useRs; useRt = v.useRt;
        isBranch = v.isBranch; useHilo = v.useHilo; exRead = v.exRead;
        exWaddr = v.exWaddr; memRead = v.memRead; memWaddr = v.memWaddr;
        flush = v.flush; multStart = 0; divStart = 0;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic doReset();
        setIdle();
        resetN = 1'b0;
        nextCycle();
        resetN = 1'b1;
    endtask

    // Reference state for the mult/div unit: busy until an absolute end cycle.
    logic        mActive;
    int          mEnd;
    int          cyc;
    logic        eStall, eDone;
    logic [31:0] expStalls;

    initial begin
        setIdle();
        resetN = 1'b0;
        #2;
        checkOutput("reset", 1, 1, 0, 0, 0);
`ifdef STALL_PERF_EN
        checkWord("reset.stall_count", stallCount, 32'd0);
`endif
        nextCycle();
        resetN = 1'b1;

        vecs.push_back(mkVec(3, 4, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(1, 3, 1, 0, 0, 0, 1, 3, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(1, 3, 1, 1, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mkVec(3, 4, 1, 1, 0, 0, 0, 3, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(5, 6, 1, 1, 1, 0, 0, 0, 1, 5, 0, 0, 0, 1));
        vecs.push_back(mkVec(5, 6, 1, 1, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0));
        vecs.push_back(mkVec(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(3, 4, 1, 1, 0, 0, 1, 3, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mkVec(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(5, 6, 1, 1, 1, 0, 0, 0, 0, 5, 0, 1, 1, 0));
        vecs.push_back(mkVec(1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0));
        vecs.push_back(mkVec(7, 9, 1, 1, 1, 0, 0, 0, 1, 9, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #2;
            checkOutput($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expIfId,
                        vecs[i].expBubble, 0, 0);
            nextCycle();
        end

        // Branch on a load in EX: load-use stall, then branch-on-load stall.
        setIdle();
        idRs = 5; idRt = 6; useRs = 1; useRt = 1; isBranch = 1;
        exRead = 1; exWaddr = 5;
        #2; checkOutput("brA.c1", 0, 0, 1, 0, 0);
        nextCycle();
        exRead = 0; exWaddr = 0; memRead = 1; memWaddr = 5;
        #2; checkOutput("brA.c2", 0, 0, 1, 0, 0);
        nextCycle();
        memRead = 0; memWaddr = 0;
        #2; checkOutput("brA.c3", 1, 1, 0, 0, 0);
        nextCycle();

        // div issued at t, mflo waiting in ID from t+1.
        setIdle();
        divStart = 1;
        #2; checkOutput("div.t", 1, 1, 0, 0, 0);
        nextCycle();
        divStart = 0; useHilo = 1;
        for (int k = 1; k <= 31; k++) begin
            #2; checkOutput($sformatf("div.t+%0d", k), 0, 0, 1, 1, 0);
            nextCycle();
        end
        #2; checkOutput("div.t+32", 1, 1, 0, 1, 1);
        nextCycle();
        useHilo = 0;
        #2; checkOutput("div.t+33", 1, 1, 0, 0, 0);
        nextCycle();

        // mult flushed two cycles after issue.
        setIdle();
        multStart = 1;
        #2; checkOutput("mulF.t", 1, 1, 0, 0, 0);
        nextCycle();
        multStart = 0;
        #2; checkOutput("mulF.t+1", 1, 1, 0, 1, 0);
        nextCycle();
        flush = 1;
        #2; checkOutput("mulF.t+2", 1, 1, 1, 1, 0);
        nextCycle();
        flush = 0;
        for (int k = 3; k <= 8; k++) begin
            #2; checkOutput($sformatf("mulF.t+%0d", k), 1, 1, 0, 0, 0);
            nextCycle();
        end

        // Randomized run against the timeline model.
        doReset();
        mActive = 0; mEnd = 0; cyc = 0; expStalls = '0;
        for (int n = 0; n < 600; n++) begin
            idRs      = 5'($urandom_range(0, 3));
            idRt      = 5'($urandom_range(0, 3));
            exWaddr   = 5'($urandom_range(0, 3));
            memWaddr  = 5'($urandom_range(0, 3));
            useRs     = 1'($urandom_range(0, 1));
            useRt     = 1'($urandom_range(0, 1));
            isBranch  = ($urandom_range(0, 3) == 0);
            useHilo   = ($urandom_range(0, 2) == 0);
            exRead    = ($urandom_range(0, 2) == 0);
            memRead   = ($urandom_range(0, 2) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            multStart = ($urandom_range(0, 9) == 0);
            divStart  = ($urandom_range(0, 29) == 0);

            eDone  = mActive && (cyc == mEnd) && !flush;
            eStall = !flush && (
                     (exRead && ((useRs && idRs != 0 && idRs == exWaddr) ||
                                 (useRt && idRt != 0 && idRt == exWaddr))) ||
                     (isBranch && memRead && ((useRs && idRs != 0 && idRs == memWaddr) ||
                                              (useRt && idRt != 0 && idRt == memWaddr))) ||
                     (useHilo && (multStart || divStart || (mActive && !eDone))));
            #2;
            checkOutput($sformatf("rnd%0d", n), !eStall, !eStall, eStall || flush, mActive, eDone);
`ifdef STALL_PERF_EN
            checkWord($sformatf("rnd%0d.stall_count", n), stallCount, expStalls);
`endif
            if (eStall) expStalls = expStalls + 32'd1;
            if (flush) begin
                mActive = 0;
            end else if (mActive && cyc == mEnd) begin
                mActive = 0;
            end else if (!mActive && (multStart || divStart)) begin
                mActive = 1;
                mEnd = cyc + (divStart ? 32 : 4);
            end
            cyc++;
            nextCycle();
        end

        // Asynchronous reset in the middle of a div abandons it.
        setIdle();
        divStart = 1;
        nextCycle();
        divStart = 0;
        for (int k = 0; k < 5; k++) nextCycle();
        #2;
        checkBit("rstMid.busyBefore", mdBusy, 1'b1);
        resetN = 1'b0;
        #1;
        checkOutput("rstMid.during", 1, 1, 0, 0, 0);
`ifdef STALL_PERF_EN
        checkWord("rstMid.stall_count", stallCount, 32'd0);
`endif
        nextCycle();
        resetN = 1'b1;
        for (int k = 0; k < 40; k++) begin
            #2; checkOutput($sformatf("rstMid.after%0d", k), 1, 1, 0, 0, 0);
            nextCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
